fib_controller: RTL

Control FSM that sits directly upstream of the stack-based Fibonacci datapath and sequences it through one computation. It drives every datapath control strobe (select, load, push, pop, accumulate, clear) and consumes the datapath's `gt` and `is_empty` status. It exposes a start/busy/done handshake to the top level.

The datapath's 5-bit `result` is the leaf count of the recursion tree. This uses the convention F(0)=F(1)=1, so N=7 gives 21.

---
 rtl/fib_controller.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fib_controller.sv
// Sequencing FSM for the stack-based Fibonacci datapath (start/busy/done handshake).
// Optional FIB_CTRL_CYCLE_CNT_EN adds an 8-bit `cycles` output counting busy cycles.
module fib_controller (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       gt,
  input  logic       is_empty,
  output logic       dp_clr,
  output logic       sel_reg,
  output logic       ld,
  output logic       sel_cmp,
  output logic       sel_sub,
  output logic       push,
  output logic       pop,
  output logic       en,
  output logic       busy,
`ifdef FIB_CTRL_CYCLE_CNT_EN
  output logic [7:0] cycles,
`endif
  output logic       done
);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StInit   = 4'd1;
  localparam logic [3:0] StLoad   = 4'd2;
  localparam logic [3:0] StCheck  = 4'd3;
  localparam logic [3:0] StPush1  = 4'd4;
  localparam logic [3:0] StPush2  = 4'd5;
  localparam logic [3:0] StAdd    = 4'd6;
  localparam logic [3:0] StPopChk = 4'd7;
  localparam logic [3:0] StDone   = 4'd8;

  logic [3:0] state_q, state_d;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dp_clr  = 1'b0;
    sel_reg = 1'b0;
    ld      = 1'b0;
    sel_cmp = 1'b0;
    sel_sub = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    en      = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StInit;
      end
      StInit: begin
        busy    = 1'b1;
        dp_clr  = 1'b1;
        state_d = StLoad;
      end
      StLoad: begin
        busy    = 1'b1;
        sel_reg = 1'b1;
        ld      = 1'b1;
        state_d = StCheck;
      end
      StCheck: begin
        busy    = 1'b1;
        state_d = gt ? StPush1 : StAdd;
      end
      StPush1: begin
        busy    = 1'b1;
        push    = 1'b1;
        state_d = StPush2;
      end
      StPush2: begin
        busy    = 1'b1;
        sel_sub = 1'b1;
        push    = 1'b1;
        state_d = StPopChk;
      end
      StAdd: begin
        busy    = 1'b1;
        en      = 1'b1;
        state_d = StPopChk;
      end
      StPopChk: begin
        busy = 1'b1;
        // Register reloads from the stack top on the same edge as the pop.
        if (!is_empty) begin
          pop     = 1'b1;
          ld      = 1'b1;
          state_d = StCheck;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        done = 1'b1;
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef FIB_CTRL_CYCLE_CNT_EN
  logic [7:0] cycles_q, cycles_d;

  // Zeroed on the IDLE->INIT edge so INIT itself is counted by the time DONE is reached.
  always_comb begin
    cycles_d = cycles_q;
    if (state_q == StIdle && start) begin
      cycles_d = 8'd0;
    end else if (busy) begin
      cycles_d = cycles_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cycles_q <= 8'd0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles = cycles_q;
`endif

endmodule
